// File: rtl/caravel_hk_pkg.sv
// Shared constants and state types for the housekeeping SPI / GPIO chain block.
package caravel_hk_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h40;
    localparam logic [7:0] CMD_RW    = 8'hC0;

    localparam logic [7:0] ADDR_PRODUCT_ID = 8'h03;
    localparam logic [7:0] ADDR_BITBANG    = 8'h13;

    // Bit positions inside the 0x13 bit-bang control register.
    localparam int unsigned BB_XFER   = 0;
    localparam int unsigned BB_ENABLE = 1;
    localparam int unsigned BB_RESETN = 2;
    localparam int unsigned BB_CLOCK  = 3;
    localparam int unsigned BB_DATA1  = 4;
    localparam int unsigned BB_DATA2  = 5;
    localparam int unsigned BB_LOAD   = 6;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_COMMAND,
        SPI_ADDRESS,
        SPI_DATA,
        SPI_IGNORE
    } spi_state_t;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_SHIFT,
        XF_LOAD
    } xfer_state_t;

endpackage

// File: rtl/caravel_hk_spi_slave.sv
// Mode-0 SPI slave: synchronises the pins, decodes command/address and streams register bytes.
module caravel_hk_spi_slave
    import caravel_hk_pkg::*;
(
    input  logic       clock,
    input  logic       resetb,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    input  logic [7:0] rdata,
    output logic       sdo,
    output logic       sdo_enb,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       we
);

    logic [1:0] sck_sync;
    logic [1:0] csb_sync;
    logic [1:0] sdi_sync;
    logic       sck_q;
    logic       sck_s;
    logic       csb_s;
    logic       sdi_s;
    logic       sck_rise_c;
    logic       sck_fall_c;
    logic       byte_done_c;
    logic [7:0] byte_c;

    logic [2:0] bit_cnt;
    logic [6:0] sr_in;
    logic [6:0] sr_out;
    logic       rd_mode;
    logic       wr_mode;
    logic       load_pend;
    logic       inc_pend;

    spi_state_t state;
    spi_state_t state_nx;

    assign sck_s       = sck_sync[1];
    assign csb_s       = csb_sync[1];
    assign sdi_s       = sdi_sync[1];
    assign sck_rise_c  = sck_s & ~sck_q;
    assign sck_fall_c  = ~sck_s & sck_q;
    assign byte_c      = {sr_in, sdi_s};
    assign byte_done_c = sck_rise_c && (bit_cnt == 3'd7);

    // Two-flop synchronisers plus a delayed sck for edge detection.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            sck_sync <= 2'b00;
            csb_sync <= 2'b11;
            sdi_sync <= 2'b00;
            sck_q    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            csb_sync <= {csb_sync[0], csb};
            sdi_sync <= {sdi_sync[0], sdi};
            sck_q    <= sck_s;
        end
    end

    // SPI protocol state register.
    always_ff @(posedge clock) begin
        if (!resetb) state <= SPI_IDLE;
        else         state <= state_nx;
    end

    // Next-state decode; chip select high always wins.
    always_comb begin
        state_nx = state;
        if (csb_s) begin
            state_nx = SPI_IDLE;
        end else begin
            case (state)
                SPI_IDLE:    state_nx = SPI_COMMAND;
                SPI_COMMAND: if (byte_done_c) begin
                    if (byte_c == CMD_WRITE || byte_c == CMD_READ || byte_c == CMD_RW)
                        state_nx = SPI_ADDRESS;
                    else
                        state_nx = SPI_IGNORE;
                end
                SPI_ADDRESS: if (byte_done_c) state_nx = SPI_DATA;
                SPI_DATA:    state_nx = SPI_DATA;
                SPI_IGNORE:  state_nx = SPI_IGNORE;
                default:     state_nx = SPI_IDLE;
            endcase
        end
    end

    // Shift registers, address pointer, write strobe and read-data output.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            bit_cnt   <= 3'd0;
            sr_in     <= 7'd0;
            sr_out    <= 7'd0;
            rd_mode   <= 1'b0;
            wr_mode   <= 1'b0;
            load_pend <= 1'b0;
            inc_pend  <= 1'b0;
            addr      <= 8'd0;
            wdata     <= 8'd0;
            we        <= 1'b0;
            sdo       <= 1'b0;
            sdo_enb   <= 1'b1;
        end else begin
            we <= 1'b0;
            // The write strobe sees the old pointer; it advances one cycle later.
            if (inc_pend) begin
                addr     <= addr + 8'd1;
                inc_pend <= 1'b0;
            end
            if (csb_s) begin
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
                sdo       <= 1'b0;
                sdo_enb   <= 1'b1;
            end else begin
                if (sck_rise_c) begin
                    sr_in   <= byte_c[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done_c) begin
                    case (state)
                        SPI_COMMAND: begin
                            rd_mode <= (byte_c == CMD_READ)  || (byte_c == CMD_RW);
                            wr_mode <= (byte_c == CMD_WRITE) || (byte_c == CMD_RW);
                        end
                        SPI_ADDRESS: begin
                            addr      <= byte_c;
                            load_pend <= rd_mode;
                        end
                        SPI_DATA: begin
                            we        <= wr_mode;
                            wdata     <= byte_c;
                            inc_pend  <= 1'b1;
                            load_pend <= rd_mode;
                        end
                        default: ;
                    endcase
                end
                if (sck_fall_c && state == SPI_DATA) begin
                    if (load_pend) begin
                        sdo       <= rdata[7];
                        sr_out    <= rdata[6:0];
                        load_pend <= 1'b0;
                        sdo_enb   <= 1'b0;
                    end else begin
                        sdo    <= sr_out[6];
                        sr_out <= {sr_out[5:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/caravel_hkspi_bitbang.sv
// Housekeeping register file plus GPIO configuration chain driver (bit-bang or automatic).
module caravel_hkspi_bitbang
    import caravel_hk_pkg::*;
#(
    parameter int unsigned CHAIN_BITS = 247,
    parameter logic [7:0]  PRODUCT_ID = 8'h10
) (
    input  logic                  clock,
    input  logic                  resetb,
    input  logic                  sck,
    input  logic                  csb,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  sdo_enb,
    input  logic [CHAIN_BITS-1:0] cfg_data_1,
    input  logic [CHAIN_BITS-1:0] cfg_data_2,
    output logic                  serial_clock,
    output logic                  serial_resetn,
    output logic                  serial_load,
    output logic                  serial_data_1,
    output logic                  serial_data_2,
    output logic                  xfer_busy
);

    localparam int unsigned CNT_W = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;

    logic [7:0]            addr;
    logic [7:0]            wdata;
    logic                  we;
    logic [7:0]            rdata_c;
    logic [6:0]            bb_reg;
    logic                  rst_done;
    logic                  wr_bb_c;
    logic                  start_c;
    logic                  abort_c;
    logic                  last_bit_c;
    logic                  unused_c;
    logic [1:0]            phase;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CHAIN_BITS-1:0] sh1;
    logic [CHAIN_BITS-1:0] sh2;

    xfer_state_t xstate;
    xfer_state_t xstate_nx;

    caravel_hk_spi_slave u_spi (
        .clock   (clock),
        .resetb  (resetb),
        .sck     (sck),
        .csb     (csb),
        .sdi     (sdi),
        .rdata   (rdata_c),
        .sdo     (sdo),
        .sdo_enb (sdo_enb),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we)
    );

    assign unused_c   = wdata[7];
    assign wr_bb_c    = we && (addr == ADDR_BITBANG);
    assign start_c    = wr_bb_c && (xstate == XF_IDLE) && wdata[BB_XFER] && !wdata[BB_ENABLE];
    assign abort_c    = wr_bb_c && (xstate != XF_IDLE) && wdata[BB_ENABLE];
    assign last_bit_c = (phase == 2'd3) && (bit_cnt == CNT_W'(CHAIN_BITS - 1));

    // Register read mux.
    always_comb begin
        rdata_c = 8'h00;
        if (addr == ADDR_PRODUCT_ID)   rdata_c = PRODUCT_ID;
        else if (addr == ADDR_BITBANG) rdata_c = {1'b0, bb_reg};
    end

    // Control register: bit 0 is only set by an accepted start and clears on finish or abort.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            bb_reg   <= 7'd0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (wr_bb_c) bb_reg[6:1] <= wdata[6:1];
            if (start_c)                              bb_reg[BB_XFER] <= 1'b1;
            else if (abort_c || xstate == XF_LOAD)    bb_reg[BB_XFER] <= 1'b0;
        end
    end

    // Transfer state register.
    always_ff @(posedge clock) begin
        if (!resetb) xstate <= XF_IDLE;
        else         xstate <= xstate_nx;
    end

    // Transfer sequencing: shift all bits, one load cycle, back to idle.
    always_comb begin
        xstate_nx = xstate;
        case (xstate)
            XF_IDLE:  if (start_c) xstate_nx = XF_SHIFT;
            XF_SHIFT: begin
                if (abort_c)         xstate_nx = XF_IDLE;
                else if (last_bit_c) xstate_nx = XF_LOAD;
            end
            XF_LOAD:  xstate_nx = XF_IDLE;
            default:  xstate_nx = XF_IDLE;
        endcase
    end

    // Chain shift registers and the 4-phase bit timer.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            phase   <= 2'd0;
            bit_cnt <= '0;
            sh1     <= '0;
            sh2     <= '0;
        end else if (start_c) begin
            phase   <= 2'd0;
            bit_cnt <= '0;
            sh1     <= cfg_data_1;
            sh2     <= cfg_data_2;
        end else if (xstate == XF_SHIFT) begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                sh1     <= {sh1[CHAIN_BITS-2:0], 1'b0};
                sh2     <= {sh2[CHAIN_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Chain pins come straight from the register in bit-bang mode, else from the engine.
    assign xfer_busy     = (xstate != XF_IDLE);
    assign serial_clock  = bb_reg[BB_ENABLE] ? bb_reg[BB_CLOCK]
                         : (xstate == XF_SHIFT) && (phase == 2'd1 || phase == 2'd2);
    assign serial_resetn = bb_reg[BB_ENABLE] ? bb_reg[BB_RESETN] : rst_done;
    assign serial_load   = bb_reg[BB_ENABLE] ? bb_reg[BB_LOAD]   : (xstate == XF_LOAD);
    assign serial_data_1 = bb_reg[BB_ENABLE] ? bb_reg[BB_DATA1]
                         : (xstate == XF_SHIFT) && sh1[CHAIN_BITS-1];
    assign serial_data_2 = bb_reg[BB_ENABLE] ? bb_reg[BB_DATA2]
                         : (xstate == XF_SHIFT) && sh2[CHAIN_BITS-1];

endmodule

// File: tb/tb_caravel_hkspi_bitbang.sv
// Directed bench: SPI register access, bit-bang chain control and automatic transfers.
`timescale 1ns/1ps
module tb_caravel_hkspi_bitbang;

    localparam int unsigned CB   = 247;
    localparam int          HALF = 6;

    logic          clock  = 1'b0;
    logic          resetb = 1'b0;
    logic          sck    = 1'b0;
    logic          csb    = 1'b1;
    logic          sdi    = 1'b0;
    logic [CB-1:0] cfg_data_1 = '0;
    logic [CB-1:0] cfg_data_2 = '0;
    logic          sdo, sdo_enb, serial_clock, serial_resetn, serial_load;
    logic          serial_data_1, serial_data_2, xfer_busy;

    int errors = 0;
    int checks = 0;

    logic [CB-1:0] chain1 = '0;
    logic [CB-1:0] chain2 = '0;
    int            clk_pulses  = 0;
    int            load_pulses = 0;
    logic          sc_prev = 1'b0;
    logic          ld_prev = 1'b0;

    always #5 clock = ~clock;

    caravel_hkspi_bitbang #(.CHAIN_BITS(CB), .PRODUCT_ID(8'h10)) dut (
        .clock         (clock),
        .resetb        (resetb),
        .sck           (sck),
        .csb           (csb),
        .sdi           (sdi),
        .sdo           (sdo),
        .sdo_enb       (sdo_enb),
        .cfg_data_1    (cfg_data_1),
        .cfg_data_2    (cfg_data_2),
        .serial_clock  (serial_clock),
        .serial_resetn (serial_resetn),
        .serial_load   (serial_load),
        .serial_data_1 (serial_data_1),
        .serial_data_2 (serial_data_2),
        .xfer_busy     (xfer_busy)
    );

    // Model of the downstream chains: shift on each serial_clock rise, count load pulses.
    always @(negedge clock) begin
        if (serial_clock === 1'b1 && sc_prev === 1'b0) begin
            chain1     <= {chain1[CB-2:0], serial_data_1};
            chain2     <= {chain2[CB-2:0], serial_data_2};
            clk_pulses <= clk_pulses + 1;
        end
        if (serial_load === 1'b1 && ld_prev === 1'b0) load_pulses <= load_pulses + 1;
        sc_prev <= serial_clock;
        ld_prev <= serial_load;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sdi = tx[i];
            wait_cyc(HALF);
            rx[i] = sdo;
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic spi_begin();
        csb = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic spi_end();
        wait_cyc(HALF);
        csb = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rx;
        spi_begin();
        spi_xfer(8'h80, rx);
        spi_xfer(a, rx);
        spi_xfer(d, rx);
        spi_end();
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [7:0] d, output logic enb);
        logic [7:0] rx;
        spi_begin();
        spi_xfer(8'h40, rx);
        spi_xfer(a, rx);
        spi_xfer(8'h00, d);
        enb = sdo_enb;
        spi_end();
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        wait_cyc(3);
        checks++;
        if ({sdo, sdo_enb, serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2, xfer_busy} !== 8'b0100_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 01000000", {sdo, sdo_enb, serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2, xfer_busy});
        end
        resetb = 1'b1;
        wait_cyc(2);
        checks++;
        if (serial_resetn !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_resetn: got %b want 1", serial_resetn);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] d;
        logic       enb;
        reg_write(8'h13, 8'h02);
        reg_read(8'h13, d, enb);
        checks++;
        if (d !== 8'h02) begin errors++; $display("FAIL wr_rd_0x13: got %h want 02", d); end
        checks++;
        if ({serial_clock, serial_resetn} !== 2'b00) begin
            errors++; $display("FAIL wr_rd_pins: clk/resetn got %b want 00", {serial_clock, serial_resetn});
        end
        checks++;
        if (sdo_enb !== 1'b1) begin errors++; $display("FAIL wr_rd_sdo_enb_idle: got %b want 1", sdo_enb); end
    endtask

    task automatic test_bitbang_clocks();
        int p0;
        reg_write(8'h13, 8'h36);
        p0 = clk_pulses;
        for (int i = 0; i < 13; i++) begin
            reg_write(8'h13, 8'h3E);
            reg_write(8'h13, 8'h36);
        end
        checks++;
        if (clk_pulses - p0 !== 13) begin errors++; $display("FAIL bb_pulse_count: got %0d want 13", clk_pulses - p0); end
        checks++;
        if (chain1[12:0] !== 13'h1FFF) begin errors++; $display("FAIL bb_chain1: got %h want 1fff", chain1[12:0]); end
        checks++;
        if (chain2[12:0] !== 13'h1FFF) begin errors++; $display("FAIL bb_chain2: got %h want 1fff", chain2[12:0]); end
    endtask

    task automatic test_bitbang_single();
        int p0;
        reg_write(8'h13, 8'h06);
        p0 = clk_pulses;
        reg_write(8'h13, 8'h0E);
        reg_write(8'h13, 8'h06);
        checks++;
        if (clk_pulses - p0 !== 1) begin errors++; $display("FAIL bb_single_count: got %0d want 1", clk_pulses - p0); end
        checks++;
        if ({chain1[0], chain2[0]} !== 2'b00) begin errors++; $display("FAIL bb_single_data: got %b want 00", {chain1[0], chain2[0]}); end
        reg_write(8'h13, 8'h46);
        checks++;
        if (serial_load !== 1'b1) begin errors++; $display("FAIL bb_load: got %b want 1", serial_load); end
        checks++;
        if ({serial_clock, serial_resetn} !== 2'b01) begin
            errors++; $display("FAIL bb_load_pins: clk/resetn got %b want 01", {serial_clock, serial_resetn});
        end
    endtask

    task automatic test_bit0_ignored();
        logic [7:0] d;
        logic       enb;
        reg_write(8'h13, 8'h07);
        checks++;
        if (xfer_busy !== 1'b0) begin errors++; $display("FAIL bb_start_busy: got %b want 0", xfer_busy); end
        reg_read(8'h13, d, enb);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL bb_start_bit0: got %h want 06", d); end
        reg_write(8'h13, 8'h46);
    endtask

    task automatic test_auto_xfer();
        logic [255:0] big;
        logic [7:0]   d;
        logic         enb;
        int           p0, l0, n;
        big = {32'hC3A5_96E1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C,
               32'hF00D_BEEF, 32'h5555_AAAA, 32'h8001_7FFE, 32'hDEAD_C0DE};
        cfg_data_1 = big[CB-1:0];
        cfg_data_2 = ~big[CB-1:0];
        p0 = clk_pulses;
        l0 = load_pulses;
        reg_write(8'h13, 8'h01);
        checks++;
        if (xfer_busy !== 1'b1) begin errors++; $display("FAIL auto_busy_start: got %b want 1", xfer_busy); end
        n = 0;
        while (xfer_busy === 1'b1 && n < 3000) begin wait_cyc(1); n++; end
        checks++;
        if (xfer_busy !== 1'b0) begin errors++; $display("FAIL auto_busy_timeout: busy=%b after %0d cycles want 0", xfer_busy, n); end
        wait_cyc(2);
        checks++;
        if (clk_pulses - p0 !== CB) begin errors++; $display("FAIL auto_pulse_count: got %0d want %0d", clk_pulses - p0, CB); end
        checks++;
        if (chain1 !== big[CB-1:0]) begin errors++; $display("FAIL auto_chain1: got %h want %h", chain1, big[CB-1:0]); end
        checks++;
        if (chain2 !== ~big[CB-1:0]) begin errors++; $display("FAIL auto_chain2: got %h want %h", chain2, ~big[CB-1:0]); end
        checks++;
        if (load_pulses - l0 !== 1) begin errors++; $display("FAIL auto_load_count: got %0d want 1", load_pulses - l0); end
        checks++;
        if ({serial_clock, serial_resetn, serial_load} !== 3'b010) begin
            errors++; $display("FAIL auto_idle_pins: clk/resetn/load got %b want 010", {serial_clock, serial_resetn, serial_load});
        end
        reg_read(8'h13, d, enb);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL auto_bit0_clear: got %h want 00", d); end
    endtask

    task automatic test_rw_and_stream();
        logic [7:0] d, rx;
        spi_begin();
        spi_xfer(8'hC0, rx);
        spi_xfer(8'h13, rx);
        spi_xfer(8'h06, d);
        spi_end();
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rw_old_value: got %h want 00", d); end
        spi_begin();
        spi_xfer(8'h40, rx);
        spi_xfer(8'h12, rx);
        spi_xfer(8'h00, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL stream_0x12: got %h want 00", d); end
        spi_xfer(8'h00, d);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL stream_0x13: got %h want 06", d); end
        spi_xfer(8'h00, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL stream_0x14: got %h want 00", d); end
        spi_end();
    endtask

    task automatic test_map();
        logic [7:0] d;
        logic       enb;
        reg_read(8'h03, d, enb);
        checks++;
        if (d !== 8'h10) begin errors++; $display("FAIL map_product_id: got %h want 10", d); end
        checks++;
        if (enb !== 1'b0) begin errors++; $display("FAIL map_sdo_enb_read: got %b want 0", enb); end
        reg_read(8'h20, d, enb);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL map_0x20_read: got %h want 00", d); end
        reg_write(8'h20, 8'h5A);
        reg_read(8'h20, d, enb);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL map_0x20_after_write: got %h want 00", d); end
    endtask

    task automatic test_csb_abort();
        logic [7:0] d, rx;
        logic       enb;
        spi_begin();
        spi_xfer(8'h80, rx);
        spi_xfer(8'h13, rx);
        for (int i = 0; i < 5; i++) begin
            sdi = 1'b1;
            wait_cyc(HALF);
            sck = 1'b1;
            wait_cyc(HALF);
            sck = 1'b0;
        end
        spi_end();
        reg_read(8'h13, d, enb);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL csb_partial_byte: got %h want 06", d); end
    endtask

    task automatic test_abort_to_bitbang();
        logic [7:0] d;
        logic       enb;
        reg_write(8'h13, 8'h01);
        checks++;
        if (xfer_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", xfer_busy); end
        reg_write(8'h13, 8'h06);
        checks++;
        if (xfer_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", xfer_busy); end
        checks++;
        if ({serial_clock, serial_resetn, serial_data_1} !== 3'b010) begin
            errors++; $display("FAIL abort_pins: clk/resetn/d1 got %b want 010", {serial_clock, serial_resetn, serial_data_1});
        end
        reg_read(8'h13, d, enb);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL abort_reg: got %h want 06", d); end
    endtask

    task automatic test_reset_mid_xfer();
        logic [7:0] d;
        logic       enb;
        reg_write(8'h13, 8'h01);
        wait_cyc(100);
        checks++;
        if (xfer_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b want 1", xfer_busy); end
        resetb = 1'b0;
        wait_cyc(2);
        checks++;
        if ({sdo, sdo_enb, serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2, xfer_busy} !== 8'b0100_0000) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 01000000", {sdo, sdo_enb, serial_clock, serial_resetn, serial_load, serial_data_1, serial_data_2, xfer_busy});
        end
        resetb = 1'b1;
        wait_cyc(2);
        checks++;
        if ({serial_resetn, xfer_busy} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_release: resetn/busy got %b want 10", {serial_resetn, xfer_busy});
        end
        reg_read(8'h13, d, enb);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_reg: got %h want 00", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bitbang_clocks();
        test_bitbang_single();
        test_bit0_ignored();
        test_auto_xfer();
        test_rw_and_stream();
        test_map();
        test_csb_abort();
        test_abort_to_bitbang();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/caravel_hkspi_bitbang.md
Name: caravel_hkspi_bitbang

Overview:
- Housekeeping SPI slave plus GPIO-configuration serial-chain driver for the Caravel management area.
- An external host writes and reads a small register file over SPI.
- Register 0x13 either bit-bangs the GPIO configuration chains (clock, resetn, load, two data lines) directly, or starts an automatic serial transfer of the configuration words supplied on input buses.
- Sits between the housekeeping SPI pins (mprj_io[4:1]) and the user-area GPIO control-block chains.

Parameters:
- CHAIN_BITS, 247, number of bits shifted per chain in an automatic transfer (19 pads x 13 bits).
- PRODUCT_ID, 8'h10, read-only value returned at address 0x03.

Ports:
- clock  in  1  system clock; all logic is in this domain.
- resetb  in  1  synchronous, active-low reset.
- sck  in  1  SPI clock (asynchronous, synchronised internally).
- csb  in  1  SPI chip select, active low.
- sdi  in  1  SPI data in.
- sdo  out  1  SPI data out.
- sdo_enb  out  1  SDO output enable, active low; 0 only while shifting read data.
- cfg_data_1  in  CHAIN_BITS  configuration word for chain 1 (user 1 / low GPIOs).
- cfg_data_2  in  CHAIN_BITS  configuration word for chain 2.
- serial_clock  out  1  chain shift clock.
- serial_resetn  out  1  chain reset, active low.
- serial_load  out  1  chain load strobe.
- serial_data_1  out  1  chain 1 data.
- serial_data_2  out  1  chain 2 data.
- xfer_busy  out  1  automatic transfer in progress.

Behaviour:
- Reset: sdo=0, sdo_enb=1, serial_clock=0, serial_resetn=0 while resetb=0 then 1, serial_load=0, serial_data_*=0, xfer_busy=0, reg 0x13=0, SPI FSM in IDLE.
- SPI input synchronisation:
  - sck, csb, sdi pass through 2-flop synchronisers; edges are detected on the synchronised sck.
  - Mode 0: sdi is sampled on sck rising; sdo is updated on sck falling. MSB first.
  - SCK high and low phases must each be at least 3 clock periods.
- SPI FSM states: IDLE -> COMMAND -> ADDRESS -> DATA.
  - csb falling (synchronised) enters COMMAND with the bit count cleared.
  - csb high at any time returns to IDLE and discards any partial byte.
  - Command byte: 0x80 = write stream, 0x40 = read stream, 0xC0 = read/write stream. Any other value: ignore the remaining bytes until csb rises.
  - The 8th bit of the address byte loads the address pointer.
  - DATA, per byte:
    - Read mode: the register at the pointer is loaded into the shift-out register on the falling edge after the address byte completes.
    - Write mode: the byte is written on its 8th rising edge.
    - Address increments by 1 after each byte and wraps at 0xFF.
  - Read/write: the old value is shifted out while the new value is shifted in.
- Register map:
  - 0x03 = PRODUCT_ID, read-only.
  - 0x13 = bit-bang control (bits 6:0); bit 7 reads 0.
  - All other addresses read 0x00 and ignore writes.
- Register 0x13 bits:
  - 0 serial_xfer start
  - 1 bit-bang enable
  - 2 bit-bang resetn
  - 3 bit-bang clock
  - 4 data 1
  - 5 data 2
  - 6 bit-bang load
- Bit-bang mode (bit1=1):
  - Outputs follow the register bits combinationally from the register, one cycle after the write: serial_clock=b3, serial_resetn=b2, serial_data_1=b4, serial_data_2=b5, serial_load=b6.
  - Writing bit0=1 in this mode is ignored and bit0 clears.
- Automatic mode (bit1=0), idle: serial_resetn=1, serial_clock=0, serial_load=0.
- Automatic transfer:
  - Writing bit0=1 starts it: xfer_busy=1 and both cfg words are captured.
  - Each bit takes 4 cycles, MSB first on both chains simultaneously: data set, clock high, clock high, clock low.
  - After CHAIN_BITS bits: one cycle with serial_load=1, then xfer_busy=0 and bit0 self-clears.
  - Writes to 0x13 during busy update bits 6:1 only; a new start is ignored.
  - Setting bit1=1 mid-transfer aborts the transfer and hands the outputs to bit-bang immediately.
- resetb low mid-transfer or mid-SPI returns everything to reset values at the next edge.

Decomposition:
- Package caravel_hk_pkg holds:
  - command codes (CMD_WRITE=8'h80, CMD_READ=8'h40, CMD_RW=8'hC0)
  - register addresses (ADDR_PRODUCT_ID=8'h03, ADDR_BITBANG=8'h13)
  - the 0x13 bit-index constants
- Natural sub-module: caravel_hk_spi_slave (synchronisers, FSM, shift registers; exposes addr / wdata / we / rdata). The top holds the register and the chain engine.

Test Plan:
- Write 0x80,0x13,0x02 then read 0x40,0x13 -> sdo returns 0x02; serial_clock=0, serial_resetn=0.
- Bit-bang: write 0x13 alternately 0x3E and 0x36 for 13 iterations -> 13 serial_clock pulses with serial_data_1=serial_data_2=1 on each rising edge; model chain captures 0x1FFF.
- Bit-bang: 0x13 = 0x06 then 0x0E then 0x06 -> exactly one serial_clock pulse with data 0; then 0x46 -> serial_load=1.
- Auto transfer: bit1=0, cfg_data_1=pattern A, cfg_data_2=~A, write 0x01 -> CHAIN_BITS clocks, model chains equal A and ~A, one load pulse, bit0 reads back 0, xfer_busy falls.
- Read 0x03 -> 0x10; read 0x20 -> 0x00; write 0x20 then read back -> still 0x00.
- csb raised after 5 bits of the data byte -> 0x13 unchanged; resetb pulsed mid auto transfer -> all outputs return to reset values and xfer_busy=0.
